// File: rtl/ones_pattern_gen.sv
// ---------------------------------------------------------------------------
// ones_pattern_gen
//
// Purpose:
//   Given a requested ones count k, emits every W-bit word that contains
//   exactly k ones, in strictly ascending numeric order, one word per
//   valid/ready handshake. Used as an exhaustive stimulus source for popcount
//   logic and weight-constrained codeword consumers.
//
// Parameters:
//   W   pattern width in bits (2..16)
//   CW  width of k; must be able to hold the value W
//   IW  width of pat_idx; must hold C(W,W/2)-1
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   start      in   1   sequence request, sampled only while idle
//   k          in   CW  requested ones count, sampled with start
//   busy       out  1   high while a sequence is in progress
//   pat_valid  out  1   pat holds a valid word
//   pat        out  W   current word, popcount(pat) == k
//   pat_idx    out  IW  0-based index of pat within the sequence
//   pat_ready  in   1   consumer accepts pat when pat_valid && pat_ready
//   done       out  1   one-cycle pulse after the last word is accepted
//   err        out  1   one-cycle pulse when a start with k > W is rejected
// ---------------------------------------------------------------------------
module ones_pattern_gen #(
    parameter int W  = 4,
    parameter int CW = 3,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] k,
    output logic          busy,
    output logic          pat_valid,
    output logic [W-1:0]  pat,
    output logic [IW-1:0] pat_idx,
    input  logic          pat_ready,
    output logic          done,
    output logic          err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state;
    // Final word of the running sequence, captured at start so the EMIT
    // state only needs an equality compare against pat.
    logic [W-1:0] last_pat;

    // Smallest word with kk ones: the kk low bits set.
    function automatic logic [W-1:0] first_pattern(input logic [CW-1:0] kk);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (i < int'(kk)) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Largest word with kk ones: the kk top bits set (zero when kk == 0).
    function automatic logic [W-1:0] last_pattern(input logic [CW-1:0] kk);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (i >= W - int'(kk)) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Next larger word with the same popcount. The lowest run of ones
    // (bits lo..hi-1) is found; bit hi is the first zero above it. Bit hi is
    // set, the run is cleared, and the remaining hi-lo-1 ones are packed into
    // the bottom bits. Only called when x is not the last word, so hi < W.
    function automatic logic [W-1:0] next_pattern(input logic [W-1:0] x);
        logic [W-1:0] r;
        int           lo;
        int           hi;
        logic         found_lo;
        logic         found_hi;
        lo       = 0;
        hi       = W;
        found_lo = 1'b0;
        found_hi = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!found_lo && x[i]) begin
                lo       = i;
                found_lo = 1'b1;
            end
        end
        for (int i = 0; i < W; i++) begin
            if (found_lo && !found_hi && i > lo && !x[i]) begin
                hi       = i;
                found_hi = 1'b1;
            end
        end
        r = x;
        for (int i = 0; i < W; i++) begin
            if (i >= lo && i < hi) r[i] = 1'b0;
            if (i == hi) r[i] = 1'b1;
        end
        for (int i = 0; i < W; i++) begin
            if (i < hi - lo - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pat_valid <= 1'b0;
            pat       <= '0;
            pat_idx   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            last_pat  <= '0;
        end else begin
            // done and err are single-cycle pulses.
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (int'(k) <= W) begin
                            state     <= EMIT;
                            busy      <= 1'b1;
                            pat_valid <= 1'b1;
                            pat       <= first_pattern(k);
                            pat_idx   <= '0;
                            last_pat  <= last_pattern(k);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // Without a handshake everything holds, which gives the
                    // backpressure behaviour for free.
                    if (pat_ready) begin
                        if (pat == last_pat) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            pat_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            pat     <= next_pattern(pat);
                            pat_idx <= pat_idx + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_ones_pattern_gen
//
// Purpose:
//   Self-checking bench for ones_pattern_gen (W=4). Expected sequences come
//   from a reference list built by scanning all W-bit values and keeping
//   those whose popcount equals k, in ascending order.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_ones_pattern_gen;

    localparam int W  = 4;
    localparam int CW = 3;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] k;
    logic          busy;
    logic          pat_valid;
    logic [W-1:0]  pat;
    logic [IW-1:0] pat_idx;
    logic          pat_ready;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    ones_pattern_gen #(.W(W), .CW(CW), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k         (k),
        .busy      (busy),
        .pat_valid (pat_valid),
        .pat       (pat),
        .pat_idx   (pat_idx),
        .pat_ready (pat_ready),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: every W-bit value with popcount kk, ascending.
    task automatic model(input int kk);
        exp_q.delete();
        for (int v = 0; v < (1 << W); v++) begin
            if ($countones(v) == kk) exp_q.push_back(v);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_pat_valid"}, 32'(pat_valid), 32'd0);
        check({tag, "_pat"},       32'(pat),       32'd0);
        check({tag, "_pat_idx"},   32'(pat_idx),   32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: 3-cycle stall at index 1.
    // poke: pulse start with k=2 while the sequence is running.
    task automatic run_seq(input int kk, input int mode, input bit poke);
        int idx;
        int stall;
        int cyc;
        bit rdy;
        model(kk);
        k     = CW'(kk);
        start = 1'b1;
        step();
        start = 1'b0;
        idx   = 0;
        stall = 0;
        cyc   = 0;
        while (idx < exp_q.size() && cyc < 500) begin
            check("seq_pat_valid", 32'(pat_valid), 32'd1);
            check("seq_busy",      32'(busy),      32'd1);
            check("seq_pat",       32'(pat),       32'(exp_q[idx]));
            check("seq_pat_idx",   32'(pat_idx),   32'(idx));
            check("seq_done",      32'(done),      32'd0);
            check("seq_err",       32'(err),       32'd0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (idx == 1 && stall < 3) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            pat_ready = rdy;
            if (poke && idx == 1) begin
                start = 1'b1;
                k     = 3'd2;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
            if (rdy) idx++;
        end
        start     = 1'b0;
        pat_ready = 1'b0;
        check("seq_complete",     32'(idx),       32'(exp_q.size()));
        check("done_pulse",       32'(done),      32'd1);
        check("valid_after_done", 32'(pat_valid), 32'd0);
        check("busy_after_done",  32'(busy),      32'd0);
        check("pat_hold",         32'(pat),       32'(exp_q[exp_q.size()-1]));
        check("idx_hold",         32'(pat_idx),   32'(exp_q.size()-1));
        step();
        check("done_single", 32'(done),      32'd0);
        check("idle_valid",  32'(pat_valid), 32'd0);
        check("idle_busy",   32'(busy),      32'd0);
    endtask

    task automatic err_test(input int kk);
        k     = CW'(kk);
        start = 1'b1;
        step();
        start = 1'b0;
        check("err_pulse",     32'(err),       32'd1);
        check("err_no_done",   32'(done),      32'd0);
        check("err_pat_valid", 32'(pat_valid), 32'd0);
        check("err_busy",      32'(busy),      32'd0);
        step();
        check("err_single",    32'(err),       32'd0);
        check("err_done_low",  32'(done),      32'd0);
        check("err_valid_low", 32'(pat_valid), 32'd0);
        check("err_busy_low",  32'(busy),      32'd0);
    endtask

    initial begin
        int kk;
        rst       = 1'b1;
        start     = 1'b0;
        k         = '0;
        pat_ready = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        step();
        check_reset_values("post_reset");

        // k=2, ready held high: six words on consecutive cycles.
        run_seq(2, 0, 1'b0);
        // Boundary counts.
        run_seq(0, 0, 1'b0);
        run_seq(4, 0, 1'b0);
        // Rejected request.
        err_test(5);
        // Backpressure on the second word.
        run_seq(1, 2, 1'b0);

        // Reset mid-sequence after the first word is accepted.
        model(3);
        k     = 3'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rst_seq_first", 32'(pat), 32'(exp_q[0]));
        pat_ready = 1'b1;
        step();
        check("rst_seq_second", 32'(pat),     32'(exp_q[1]));
        check("rst_seq_idx1",   32'(pat_idx), 32'd1);
        rst = 1'b1;
        step();
        rst       = 1'b0;
        pat_ready = 1'b0;
        check_reset_values("mid_reset");
        step();
        check_reset_values("mid_reset_idle");
        run_seq(1, 0, 1'b0);

        // start while busy is ignored.
        run_seq(3, 0, 1'b1);

        // Randomized requests and backpressure.
        for (int n = 0; n < 25; n++) begin
            kk = int'($urandom_range(0, 7));
            if (kk > W) err_test(kk);
            else        run_seq(kk, 1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
